// File: rtl/pll_sup_pkg.sv
// Shared types and widths for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_sup_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int LOSS_CNT_W  = 8;
  localparam int RETRY_CNT_W = 4;

  // Keeps a counter at least one bit wide when its limit is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// N-flop synchronizer for an asynchronous status input; clears to 0 on reset.
module lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Lock supervisor and reset sequencer for the video PLL, clocked by the PLL reference.
// Releases sys_resetn only after a continuous lock; retries and latches a fault.
//
// state        | meaning
// ST_RESET_PLL | PLL held in reset for PLL_RST_CYCLES cycles
// ST_WAIT_LOCK | waiting for synchronized lock, timeout running
// ST_STABLE    | lock seen, counting consecutive high cycles, timeout running
// ST_RUN       | lock stable, downstream released
// ST_FAULT     | retries exhausted, PLL held in reset until relock_req
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pll_lock,
  input  logic                  relock_req,
  output logic                  pll_rst,
  output logic                  sys_resetn,
  output logic                  locked,
  output logic                  fault,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam int RST_W = cnt_width(PLL_RST_CYCLES);
  localparam int TMO_W = cnt_width(LOCK_TIMEOUT);
  localparam int STB_W = cnt_width(STABLE_CYCLES);

  localparam logic [RST_W-1:0]       RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMO_W-1:0]       TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0]       STB_LAST  = STB_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_CNT_W-1:0] RETRY_MAX = RETRY_CNT_W'(MAX_RETRIES);

  logic lock_s;

  pll_sup_state_t state_q, state_d;

  logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [STB_W-1:0]       stb_cnt_q, stb_cnt_d;
  logic [RETRY_CNT_W-1:0] retry_q, retry_d;
  logic [RETRY_CNT_W-1:0] retry_inc;
  logic [LOSS_CNT_W-1:0]  loss_cnt_q, loss_cnt_d;

  logic pll_rst_q, pll_rst_d;
  logic sys_resetn_q, sys_resetn_d;
  logic locked_q, locked_d;
  logic fault_q, fault_d;

  logic relock_take;
  logic acquiring;
  logic stb_done;
  logic tmo_fire;

  lock_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pll_lock),
    .q      (lock_s)
  );

  // A relock request is dropped while the PLL is already being reset.
  assign relock_take = relock_req && (state_q != ST_RESET_PLL);
  assign acquiring   = (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE);
  assign stb_done    = (state_q == ST_STABLE) && lock_s && (stb_cnt_q == STB_LAST);
  // Reaching RUN on the last allowed cycle counts as a successful lock.
  assign tmo_fire    = acquiring && (tmo_cnt_q == TMO_LAST) && !stb_done && !relock_take;
  assign retry_inc   = retry_q + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_RESET_PLL;
      rst_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      stb_cnt_q    <= '0;
      retry_q      <= '0;
      loss_cnt_q   <= '0;
      pll_rst_q    <= 1'b1;
      sys_resetn_q <= 1'b0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      stb_cnt_q    <= stb_cnt_d;
      retry_q      <= retry_d;
      loss_cnt_q   <= loss_cnt_d;
      pll_rst_q    <= pll_rst_d;
      sys_resetn_q <= sys_resetn_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET_PLL: if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (lock_s) state_d = ST_STABLE;
      ST_STABLE: begin
        if (stb_done) begin
          state_d = ST_RUN;
        end else if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_RUN:   if (!lock_s) state_d = ST_RESET_PLL;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RESET_PLL;
    endcase
    if (tmo_fire) begin
      state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_RESET_PLL;
    end
    if (relock_take) begin
      state_d = ST_RESET_PLL;
    end
  end

  always_comb begin
    rst_cnt_d = '0;
    tmo_cnt_d = '0;
    stb_cnt_d = '0;
    if ((state_q == ST_RESET_PLL) && (state_d == ST_RESET_PLL)) begin
      rst_cnt_d = rst_cnt_q + 1'b1;
    end
    // The timeout spans WAIT_LOCK and STABLE so a chattering lock still expires.
    if (acquiring && ((state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE))) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    if ((state_q == ST_STABLE) && (state_d == ST_STABLE)) begin
      stb_cnt_d = stb_cnt_q + 1'b1;
    end

    retry_d = retry_q;
    if (relock_take || (state_d == ST_RUN)) begin
      retry_d = '0;
    end else if (tmo_fire) begin
      retry_d = retry_inc;
    end

    loss_cnt_d = loss_cnt_q;
    if ((state_q == ST_RUN) && !lock_s && !relock_take && (loss_cnt_q != '1)) begin
      loss_cnt_d = loss_cnt_q + 1'b1;
    end
  end

  always_comb begin
    pll_rst_d    = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    sys_resetn_d = (state_d == ST_RUN);
    locked_d     = (state_d == ST_RUN);
    fault_d      = (state_d == ST_FAULT);
  end

  assign pll_rst    = pll_rst_q;
  assign sys_resetn = sys_resetn_q;
  assign locked     = locked_q;
  assign fault      = fault_q;
  assign loss_cnt   = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor against a phase/streak reference model.
module tb_pll_lock_supervisor;

  localparam int N_RST = 4;
  localparam int T_OUT = 20;
  localparam int S_LCK = 8;
  localparam int M_RTY = 2;

  localparam int P_RST   = 0;
  localparam int P_ACQ   = 1;
  localparam int P_RUN   = 2;
  localparam int P_FAULT = 3;

  typedef struct packed {
    logic       pll_rst;
    logic       sys_resetn;
    logic       locked;
    logic       fault;
    logic [7:0] loss;
  } obs_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_resetn;
  logic       locked;
  logic       fault;
  logic [7:0] loss_cnt;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cycle  = 0;

  // Reference model: attempt age, consecutive synchronized-lock streak, counters.
  int   m_phase;
  int   m_rst_left;
  int   m_age;
  int   m_streak;
  int   m_retries;
  int   m_losses;
  logic m_s1;
  logic m_s2;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (N_RST),
    .LOCK_TIMEOUT   (T_OUT),
    .STABLE_CYCLES  (S_LCK),
    .MAX_RETRIES    (M_RTY)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pll_lock   (pll_lock),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_resetn (sys_resetn),
    .locked     (locked),
    .fault      (fault),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk = ~clk;

  function automatic obs_t model_obs();
    obs_t o;
    o.pll_rst    = (m_phase == P_RST) || (m_phase == P_FAULT);
    o.sys_resetn = (m_phase == P_RUN);
    o.locked     = (m_phase == P_RUN);
    o.fault      = (m_phase == P_FAULT);
    o.loss       = 8'(m_losses);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.pll_rst    = pll_rst;
    o.sys_resetn = sys_resetn;
    o.locked     = locked;
    o.fault      = fault;
    o.loss       = loss_cnt;
    return o;
  endfunction

  task automatic start_reset_phase();
    m_phase    = P_RST;
    m_rst_left = N_RST;
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic model_step(input logic rn, input logic lk, input logic rq);
    logic ls;
    if (!rn) begin
      start_reset_phase();
      m_age     = 0;
      m_streak  = 0;
      m_retries = 0;
      m_losses  = 0;
      m_s1      = 1'b0;
      m_s2      = 1'b0;
    end else begin
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = lk;
      if (m_phase == P_RST) begin
        m_rst_left--;
        if (m_rst_left == 0) begin
          m_phase  = P_ACQ;
          m_age    = 0;
          m_streak = 0;
        end
      end else if (rq) begin
        start_reset_phase();
        m_retries = 0;
      end else if (m_phase == P_ACQ) begin
        m_age++;
        m_streak = ls ? m_streak + 1 : 0;
        if (m_streak == S_LCK + 1) begin
          m_phase   = P_RUN;
          m_retries = 0;
        end else if (m_age == T_OUT) begin
          m_retries++;
          if (m_retries == M_RTY) m_phase = P_FAULT;
          else start_reset_phase();
        end
      end else if (m_phase == P_RUN) begin
        if (!ls) begin
          if (m_losses < 255) m_losses++;
          start_reset_phase();
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, n_cycle, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected post-edge outputs.
  task automatic cycle(input logic rn, input logic lk, input logic rq);
    @(negedge clk);
    resetn     = rn;
    pll_lock   = lk;
    relock_req = rq;
    n_cycle++;
    model_step(rn, lk, rq);
    exp_q.push_back(model_obs());
  endtask

  task automatic async_reset_mid_cycle();
    @(negedge clk);
    pll_lock   = 1'b1;
    relock_req = 1'b0;
    n_cycle++;
    #2;
    resetn = 1'b0;
    model_step(1'b0, 1'b1, 1'b0);
    #1;
    check("async_reset_outputs", 32'(dut_obs()), 32'(model_obs()));
    check("async_reset_pll_rst", 32'(pll_rst), 32'd1);
    check("async_reset_locked", 32'(locked), 32'd0);
    exp_q.push_back(model_obs());
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        obs_t e;
        e = exp_q.pop_front();
        check("outputs{rst,sysn,lck,flt,loss}", 32'(dut_obs()), 32'(e));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_loss;
    int guard;
    resetn     = 1'b0;
    pll_lock   = 1'b0;
    relock_req = 1'b0;
    model_step(1'b0, 1'b0, 1'b0);

    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check("reset_pll_rst", 32'(pll_rst), 32'd1);
    check("reset_sys_resetn", 32'(sys_resetn), 32'd0);

    // Clean lock.
    repeat (30) cycle(1'b1, 1'b1, 1'b0);
    check("clean_lock_locked", 32'(locked), 32'd1);

    // Single-cycle lock drop in RUN.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (30) cycle(1'b1, 1'b1, 1'b0);
    check("loss_count_one", 32'(loss_cnt), 32'd1);

    // Chattering lock, toggling every 5 cycles.
    for (int i = 0; i < 120; i++) cycle(1'b1, logic'(((i / 5) % 2) == 0), 1'b0);
    check("chatter_fault", 32'(fault), 32'd1);
    check("chatter_pll_rst_held", 32'(pll_rst), 32'd1);

    // Fault recovery.
    cycle(1'b1, 1'b1, 1'b1);
    repeat (20) cycle(1'b1, 1'b1, 1'b0);
    check("recover_locked", 32'(locked), 32'd1);

    // Relock request coinciding with synchronized lock loss in RUN.
    saved_loss = m_losses;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    repeat (20) cycle(1'b1, 1'b1, 1'b0);
    check("simul_loss_unchanged", 32'(loss_cnt), 32'(saved_loss));

    // Randomized lock and relock traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'b1, logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 63) == 0));
    end

    // Async reset asserted between edges while in STABLE.
    cycle(1'b1, 1'b1, 1'b1);
    guard = 0;
    while (!(m_phase == P_ACQ && m_streak >= 2) && guard < 100) begin
      cycle(1'b1, 1'b1, 1'b0);
      guard++;
    end
    check("reach_stable_in_budget", 32'(guard < 100), 32'd1);
    async_reset_mid_cycle();
    repeat (2) cycle(1'b0, 1'b1, 1'b0);
    repeat (20) cycle(1'b1, 1'b1, 1'b0);

    // Loss counter saturation.
    for (int k = 0; k < 260; k++) begin
      repeat (18 + $urandom_range(0, 4)) cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
    end
    repeat (20) cycle(1'b1, 1'b1, 1'b0);
    check("loss_saturated", 32'(loss_cnt), 32'd255);

    repeat (2) @(posedge clk);
    #4;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
